// File: rtl/imem_pkg.sv
// Shared types and constants for the run-time loadable instruction memory.
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    LOAD,
    RUN
  } state_t;

  localparam logic [31:0] NOP_WORD       = 32'h0000_0013;
  localparam int          FAULT_W        = 2;
  localparam int          FAULT_MISALIGN = 0;
  localparam int          FAULT_OOR      = 1;

endpackage

// File: rtl/imem_loadable_if.sv
// Load port plus fetch request/response channels of the instruction memory.
interface imem_loadable_if
  import imem_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64,
  parameter int AW    = 32
);

  logic                   ld_valid;
  logic                   ld_ready;
  logic [$clog2(DEPTH):0] ld_addr;
  logic [XLEN-1:0]        ld_data;
  logic                   ld_last;
  logic                   ld_err;

  logic                   f_valid;
  logic                   f_ready;
  logic [AW-1:0]          f_addr;

  logic                   r_valid;
  logic                   r_ready;
  logic [XLEN-1:0]        r_instr;
  logic [FAULT_W-1:0]     r_fault;

  modport master (
    output ld_valid, ld_addr, ld_data, ld_last, f_valid, f_addr, r_ready,
    input  ld_ready, ld_err, f_ready, r_valid, r_instr, r_fault
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_last, f_valid, f_addr, r_ready,
    output ld_ready, ld_err, f_ready, r_valid, r_instr, r_fault
  );

endinterface

// File: rtl/imem_ram.sv
// Single write port, single registered read port RAM; shaped to map onto block RAM.
module imem_ram #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 64,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            re,
  input  logic [IW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read data only advances on an accepted fetch so a stalled response stays put.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_loadable.sv
// Instruction memory filled at run time: CLEAR wipes to NOP, LOAD accepts words,
// RUN serves fetches with one cycle of latency and reports misaligned/out-of-range faults.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 64,
  parameter int              AW       = 32,
  parameter logic [XLEN-1:0] NOP_WORD = XLEN'(imem_pkg::NOP_WORD)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_req,
  output logic           busy,
  output logic           running,
  imem_loadable_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;

  state_t               state;
  logic [IW-1:0]        cnt;
  logic                 ld_ready_q;
  logic                 ld_err_q;
  logic                 r_valid_q;
  logic [FAULT_W-1:0]   r_fault_q;
  logic [XLEN-1:0]      ram_rdata;

  logic                 ld_fire;
  logic                 ld_in_range;
  logic                 drain_ok;
  logic                 f_fire;
  logic                 misaligned;
  logic                 oor;
  logic                 ram_we;
  logic [IW-1:0]        ram_waddr;
  logic [XLEN-1:0]      ram_wdata;

  assign ld_fire     = bus.ld_valid && ld_ready_q;
  assign ld_in_range = bus.ld_addr < LW'(DEPTH);
  assign drain_ok    = !r_valid_q || bus.r_ready;
  assign bus.f_ready = running && !load_req && drain_ok;
  assign f_fire      = bus.f_valid && bus.f_ready;
  assign misaligned  = |bus.f_addr[1:0];
  // Widened compare so huge addresses never wrap back into the array.
  assign oor         = 64'(bus.f_addr >> 2) >= 64'(DEPTH);

  assign bus.ld_ready = ld_ready_q;
  assign bus.ld_err   = ld_err_q;
  assign bus.r_valid  = r_valid_q;
  assign bus.r_fault  = r_fault_q;
  assign bus.r_instr  = (|r_fault_q) ? NOP_WORD : ram_rdata;

  // Clear sweep and load handshakes share the one RAM write port.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = cnt;
    ram_wdata = NOP_WORD;
    if (!reset) begin
      if (state == CLEAR) begin
        ram_we = 1'b1;
      end else if (state == LOAD && ld_fire && ld_in_range) begin
        ram_we    = 1'b1;
        ram_waddr = bus.ld_addr[IW-1:0];
        ram_wdata = bus.ld_data;
      end
    end
  end

  imem_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (f_fire),
    .raddr (bus.f_addr[IW+1:2]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      cnt        <= '0;
      busy       <= 1'b1;
      running    <= 1'b0;
      ld_ready_q <= 1'b0;
      ld_err_q   <= 1'b0;
      r_valid_q  <= 1'b0;
      r_fault_q  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == IW'(DEPTH - 1)) begin
            state      <= LOAD;
            busy       <= 1'b0;
            ld_ready_q <= 1'b1;
            ld_err_q   <= 1'b0;
          end
        end
        LOAD: begin
          if (ld_fire) begin
            if (!ld_in_range) ld_err_q <= 1'b1;
            if (bus.ld_last) begin
              state      <= RUN;
              ld_ready_q <= 1'b0;
              running    <= 1'b1;
            end
          end
        end
        RUN: begin
          if (f_fire) begin
            r_valid_q                 <= 1'b1;
            r_fault_q[FAULT_MISALIGN] <= misaligned;
            r_fault_q[FAULT_OOR]      <= oor;
          end else if (bus.r_ready) begin
            r_valid_q <= 1'b0;
          end
          // Leave RUN only once the output register is empty or being emptied.
          if (load_req && drain_ok) begin
            state      <= LOAD;
            running    <= 1'b0;
            ld_ready_q <= 1'b1;
            ld_err_q   <= 1'b0;
            r_valid_q  <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Randomised scoreboard bench for imem_loadable against an array-based reference model.
module tb_imem_loadable;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 64;
  localparam int          AW    = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  fault;
    int          acc;
    bit          chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic load_req;
  logic busy;
  logic running;

  int          cyc = 0;
  int          n_compared = 0;
  int          n_mismatched = 0;
  int          last_acc = 0;
  logic [31:0] model_mem [DEPTH];
  exp_t        sb_q [$];

  imem_loadable_if #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW)) bus ();

  imem_loadable #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .load_req (load_req),
    .busy     (busy),
    .running  (running),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic exp_t model_resp(input logic [31:0] addr, input int acc, input bit chk_lat);
    exp_t            e;
    longint unsigned a;
    longint unsigned w;
    bit              mis;
    bit              out;
    a   = addr;
    w   = a / 4;
    mis = (a % 4) != 0;
    out = w >= DEPTH;
    e.fault   = {out, mis};
    e.instr   = NOP;
    if (!mis && !out) e.instr = model_mem[w];
    e.acc     = acc;
    e.chk_lat = chk_lat;
    return e;
  endfunction

  // Monitor: every consumed response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.r_valid && bus.r_ready) begin
      if (sb_q.size() == 0) begin
        timeout_fail("unexpected_response");
      end else begin
        e = sb_q.pop_front();
        checkOutput("r_instr", bus.r_instr, e.instr);
        checkOutput("r_fault", bus.r_fault, e.fault);
        if (e.chk_lat) checkOutput("latency", 64'(cyc - e.acc), 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    load_req     = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    bus.f_valid  = 1'b0;
    tick();
    reset = 1'b0;
    sb_q.delete();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
  endtask

  task automatic check_clear(input string tag);
    int n = 0;
    checkOutput({tag, "_busy"}, busy, 1);
    checkOutput({tag, "_r_valid"}, bus.r_valid, 0);
    checkOutput({tag, "_ld_ready"}, bus.ld_ready, 0);
    checkOutput({tag, "_f_ready"}, bus.f_ready, 0);
    checkOutput({tag, "_running"}, running, 0);
    checkOutput({tag, "_ld_err"}, bus.ld_err, 0);
    while (busy && n < 200) begin
      n++;
      tick();
    end
    checkOutput({tag, "_clear_cycles"}, 64'(n), DEPTH);
    checkOutput({tag, "_ld_ready_after"}, bus.ld_ready, 1);
  endtask

  task automatic load_word(input logic [6:0] addr, input logic [31:0] data, input bit last);
    int waited = 0;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
    bus.ld_last  = last;
    @(negedge clk);
    while (!bus.ld_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.ld_ready) begin
      timeout_fail("load_accept");
      bus.ld_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (addr < DEPTH) model_mem[addr] = data;
    #1;
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input bit chk_lat, input bit rand_rr);
    int waited = 0;
    bus.f_valid = 1'b1;
    bus.f_addr  = addr;
    @(negedge clk);
    while (!bus.f_ready && waited < 50) begin
      @(posedge clk);
      #1;
      if (rand_rr) bus.r_ready = ($urandom_range(0, 3) != 0);
      waited++;
      @(negedge clk);
    end
    if (!bus.f_ready) begin
      timeout_fail("fetch_accept");
      bus.f_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb_q.push_back(model_resp(addr, cyc, chk_lat));
    last_acc = cyc;
    #1;
    bus.f_valid = 1'b0;
  endtask

  task automatic wait_running(input bit val, input string name);
    int n = 0;
    while (running !== val && n < 20) begin
      tick();
      n++;
    end
    checkOutput(name, running, val);
  endtask

  initial begin
    int          first_acc;
    logic [31:0] held;
    logic [31:0] rnd_addr;

    bus.ld_addr = '0;
    bus.ld_data = '0;
    bus.f_addr  = '0;
    bus.r_ready = 1'b1;

    // Reset and clear sweep, then a fetch of a cleared word.
    do_reset();
    check_clear("rst");
    load_word(7'd10, $urandom, 1'b1);
    wait_running(1'b1, "run_after_first_load");
    checkOutput("ld_err_first", bus.ld_err, 0);
    applyStimulus(32'h0, 1'b1, 1'b0);
    tick();

    // Return to LOAD; f_ready must drop in the same cycle as load_req.
    load_req = 1'b1;
    @(negedge clk);
    checkOutput("lreq_f_ready", bus.f_ready, 0);
    tick();
    wait_running(1'b0, "lreq_idle_to_load");
    load_req = 1'b0;
    checkOutput("reload_ld_ready", bus.ld_ready, 1);

    // Program load and back-to-back fetches.
    load_word(7'd0, 32'h00C8_06B3, 1'b0);
    load_word(7'd1, 32'h4034_02B3, 1'b0);
    load_word(7'd2, 32'h0031_70B3, 1'b0);
    load_word(7'd3, 32'h0051_E233, 1'b1);
    wait_running(1'b1, "run_after_program");
    applyStimulus(32'h0, 1'b1, 1'b0);
    first_acc = last_acc;
    applyStimulus(32'h4, 1'b1, 1'b0);
    applyStimulus(32'h8, 1'b1, 1'b0);
    applyStimulus(32'hC, 1'b1, 1'b0);
    checkOutput("back_to_back", 64'(last_acc - first_acc), 3);

    // Fault classification and boundary words.
    applyStimulus(32'h6, 1'b1, 1'b0);
    applyStimulus(32'h100, 1'b1, 1'b0);
    applyStimulus(32'h102, 1'b1, 1'b0);
    applyStimulus(32'hFC, 1'b1, 1'b0);
    applyStimulus(32'h28, 1'b1, 1'b0);
    applyStimulus(32'hFFFF_FFFC, 1'b1, 1'b0);
    tick();

    // Back-pressure: response must hold while r_ready is low.
    bus.r_ready = 1'b0;
    held = model_mem[1];
    applyStimulus(32'h4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_r_valid", bus.r_valid, 1);
      checkOutput("stall_f_ready", bus.f_ready, 0);
      checkOutput("stall_r_instr", bus.r_instr, held);
    end
    @(posedge clk);
    #1;
    bus.r_ready = 1'b1;
    tick();
    tick();
    checkOutput("stall_release_drop", bus.r_valid, 0);

    // load_req while a response is stalled.
    bus.r_ready = 1'b0;
    applyStimulus(32'h8, 1'b0, 1'b0);
    load_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("lreq_stalled_running", running, 1);
      checkOutput("lreq_stalled_r_valid", bus.r_valid, 1);
    end
    @(posedge clk);
    #1;
    bus.r_ready = 1'b1;
    wait_running(1'b0, "lreq_stalled_to_load");
    load_req = 1'b0;
    checkOutput("lreq_ld_ready", bus.ld_ready, 1);
    checkOutput("lreq_ld_err", bus.ld_err, 0);
    checkOutput("lreq_r_valid", bus.r_valid, 0);

    // Out-of-range load is dropped and flagged; ld_err survives into RUN.
    load_word(7'd64, 32'hDEAD_BEEF, 1'b0);
    checkOutput("ld_err_set", bus.ld_err, 1);
    load_word(7'd1, 32'hA5A5_0F0F, 1'b0);
    for (int i = 0; i < 8; i++) load_word(7'($urandom_range(6, 63)), $urandom, 1'b0);
    load_word(7'd5, 32'h1234_5678, 1'b1);
    wait_running(1'b1, "run_after_err_load");
    checkOutput("ld_err_sticky", bus.ld_err, 1);
    applyStimulus(32'h0, 1'b1, 1'b0);
    applyStimulus(32'h4, 1'b1, 1'b0);
    applyStimulus(32'h14, 1'b1, 1'b0);

    // Randomised fetch traffic with random back-pressure.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       rnd_addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
        1:       rnd_addr = 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'h1;
        2:       rnd_addr = $urandom;
        default: rnd_addr = 32'($urandom_range(DEPTH * 4 - 4, DEPTH * 4 + 3));
      endcase
      applyStimulus(rnd_addr, 1'b0, 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        bus.r_ready = $urandom_range(0, 1) != 0;
        tick();
      end
    end
    bus.r_ready = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("scoreboard_drained", 64'(sb_q.size()), 0);

    // Reset in the middle of LOAD restarts the clear sweep.
    load_req = 1'b1;
    wait_running(1'b0, "lreq_before_reset");
    load_req = 1'b0;
    load_word(7'd3, 32'hCAFE_F00D, 1'b0);
    bus.ld_valid = 1'b1;
    do_reset();
    check_clear("midload_rst");
    load_word(7'd2, 32'h0BAD_C0DE, 1'b1);
    wait_running(1'b1, "run_after_reset_load");
    applyStimulus(32'h8, 1'b1, 1'b0);
    applyStimulus(32'hC, 1'b1, 1'b0);
    applyStimulus(32'h4, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("final_drained", 64'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
